// File: rtl/serial_logic_unit_pkg.sv
// ============================================================================
//  Module : serial_logic_unit_pkg
//  Brief  : Shared op and state encodings for the slice-serial logic unit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_logic_unit_pkg;

    localparam logic [1:0] LOGIC_AND = 2'b00;
    localparam logic [1:0] LOGIC_OR  = 2'b01;
    localparam logic [1:0] LOGIC_XOR = 2'b10;
    localparam logic [1:0] LOGIC_NOR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serial_logic_unit_logic_slice.sv
// ============================================================================
//  Module : logic_slice
//  Brief  : SLICE-bit combinational AND/OR/XOR/NOR selected by op.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_slice
    import serial_logic_unit_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            LOGIC_AND: y = a & b;
            LOGIC_OR:  y = a | b;
            LOGIC_XOR: y = a ^ b;
            LOGIC_NOR: y = ~(a | b);
            default:   y = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/serial_logic_unit.sv
// ============================================================================
//  Module : serial_logic_unit
//  Brief  : Multi-cycle bitwise logic unit, one SLICE-bit slice per clock,
//           LSB slice first; result/zero held until the next accepted start.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_logic_unit
    import serial_logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int               c_nslice = WIDTH / SLICE;
    localparam int               c_cnt_w  = (c_nslice > 1) ? $clog2(c_nslice) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_nslice - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic [SLICE-1:0]   w_slice;
    logic [WIDTH-1:0]   w_result_upd;
    logic               w_accept;
    logic               w_last;

    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_cnt == c_last);

    logic_slice #(
        .SLICE (SLICE)
    ) u_logic_slice (
        .op (r_op),
        .a  (r_a_sh[SLICE-1:0]),
        .b  (r_b_sh[SLICE-1:0]),
        .y  (w_slice)
    );

    // Drop the freshly computed slice into the position selected by the counter.
    always_comb begin
        w_result_upd = r_result;
        for (int i = 0; i < c_nslice; i++) begin
            if (r_cnt == c_cnt_w'(i)) begin
                w_result_upd[i*SLICE +: SLICE] = w_slice;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_op     <= LOGIC_AND;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a_sh   <= a;
                r_b_sh   <= b;
                r_op     <= op;
                r_cnt    <= '0;
                r_result <= '0;
                r_zero   <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_a_sh   <= r_a_sh >> SLICE;
                r_b_sh   <= r_b_sh >> SLICE;
                r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
                r_result <= w_result_upd;
                // Unwritten upper slices are still zero, so the partial compare covers them.
                if (w_last) begin
                    r_zero <= (r_result == '0) && (w_slice == '0);
                end
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = (r_state == S_DONE);
    assign result = r_result;
    assign zero   = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_serial_logic_unit.sv
// ============================================================================
//  Module : tb_serial_logic_unit
//  Brief  : Directed self-checking bench for serial_logic_unit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_logic_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: cycles of RUN left, pending answer, expected outputs.
    int          run_left  = 0;
    logic [31:0] pend      = '0;
    logic [31:0] res_exp   = '0;
    logic        zero_exp  = 1'b0;
    logic        done_exp  = 1'b0;
    logic        res_valid = 1'b0;
    logic        chk_en    = 1'b0;

    serial_logic_unit #(
        .WIDTH (32),
        .SLICE (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            run_left  = 0;
            done_exp  = 1'b0;
            res_exp   = '0;
            zero_exp  = 1'b0;
            res_valid = 1'b1;
        end else if (start && run_left == 0) begin
            pend      = ref_op(op, a, b);
            run_left  = 8;
            done_exp  = 1'b0;
            res_valid = 1'b0;
        end else if (run_left > 0) begin
            run_left--;
            if (run_left == 0) begin
                done_exp  = 1'b1;
                res_exp   = pend;
                zero_exp  = (pend == 32'h0);
                res_valid = 1'b1;
            end
        end else begin
            done_exp = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("busy", {31'b0, busy}, {31'b0, (run_left > 0)});
            cmp("done", {31'b0, done}, {31'b0, done_exp});
            if (res_valid) begin
                cmp("result", result, res_exp);
                cmp("zero", {31'b0, zero}, {31'b0, zero_exp});
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    // n counts negedges since the accepting edge; done is due at n == 9.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int dcount;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        cmp("rst_busy",   {31'b0, busy}, 32'd0);
        cmp("rst_done",   {31'b0, done}, 32'd0);
        cmp("rst_result", result,        32'h0);
        cmp("rst_zero",   {31'b0, zero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1. OR
        issue(2'b01, 32'h0F0F_0000, 32'h00F0_00FF);
        wait_done(1, n);
        cmp("t1_latency", n, 9);
        cmp("t1_result", result, 32'h0FFF_00FF);
        cmp("t1_zero", {31'b0, zero}, 32'd0);
        repeat (3) @(negedge clk);
        cmp("t1_hold", result, 32'h0FFF_00FF);

        // 2. AND giving zero
        issue(2'b00, 32'hAAAA_AAAA, 32'h5555_5555);
        wait_done(1, n);
        cmp("t2_result", result, 32'h0);
        cmp("t2_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);

        // 3. XOR of equal operands, then NOR with operands disturbed mid-RUN
        issue(2'b10, 32'hFFFF_0000, 32'hFFFF_0000);
        wait_done(1, n);
        cmp("t3_xor", result, 32'h0);
        cmp("t3_xor_zero", {31'b0, zero}, 32'd1);
        @(negedge clk);
        issue(2'b11, 32'hFFFF_0000, 32'hFFFF_0000);
        repeat (2) @(negedge clk);
        a  = 32'h1234_5678;
        b  = 32'h0000_0000;
        op = 2'b00;
        wait_done(3, n);
        cmp("t3_nor", result, 32'h0000_FFFF);
        cmp("t3_nor_zero", {31'b0, zero}, 32'd0);
        @(negedge clk);

        // 4. start during RUN is ignored
        issue(2'b01, 32'h0000_00F0, 32'h0000_000F);
        repeat (2) @(negedge clk);
        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0000);
        wait_done(4, n);
        cmp("t4_latency", n, 9);
        cmp("t4_result", result, 32'h0000_00FF);
        dcount = 0;
        repeat (10) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        cmp("t4_single_done", dcount, 0);

        // 5. start in the DONE cycle
        issue(2'b10, 32'h1234_5678, 32'hFFFF_0000);
        wait_done(1, n);
        cmp("t5_first", result, 32'hEDCB_5678);
        cmp("t5_done_now", {31'b0, done}, 32'd1);
        issue(2'b11, 32'h0000_0000, 32'hF0F0_F0F0);
        wait_done(1, n);
        cmp("t5_gap", n, 9);
        cmp("t5_second", result, 32'h0F0F_0F0F);
        @(negedge clk);

        // 6. reset in the middle of RUN
        issue(2'b01, 32'hDEAD_BEEF, 32'h0000_0000);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("t6_busy",   {31'b0, busy}, 32'd0);
        cmp("t6_done",   {31'b0, done}, 32'd0);
        cmp("t6_result", result,        32'h0);
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
        end
        cmp("t6_no_done", dcount, 0);

        // 7. reset and start on the same edge
        reset = 1'b1;
        start = 1'b1;
        op    = 2'b01;
        a     = 32'hFFFF_FFFF;
        b     = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        cmp("t7_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);

        issue(2'b00, 32'hFF00_FF00, 32'h0FF0_0FF0);
        wait_done(1, n);
        cmp("t7_after", result, 32'h0F00_0F00);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
